// File: rtl/console_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : console_defs                                            |
// | Brief    : Console link ASCII constants and UART TX FSM encoding   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package console_defs;

    localparam logic [7:0] ASCII_STAR       = 8'h2A;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h57;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/code_ascii_uart_tx_code_to_ascii.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : code_to_ascii                                           |
// | Brief    : Key code (1..18) to ASCII '1'..'9','a'..'i', else '*'   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module code_to_ascii
    import console_defs::*;
(
    input  logic [7:0] code_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = ASCII_STAR;
        if (code_i >= 8'd1 && code_i <= 8'd9) begin
            ascii_o = ASCII_DIGIT_BASE + code_i;
        end else if (code_i >= 8'd10 && code_i <= 8'd18) begin
            ascii_o = ASCII_ALPHA_BASE + code_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/code_ascii_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : code_ascii_uart_tx                                      |
// | Brief    : Encodes key codes to ASCII, sends 8N1 UART (opt. CR LF) |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module code_ascii_uart_tx
    import console_defs::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit EOL_EN       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] ascii_out
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        ascii_q, ascii_d;
    logic [1:0]        eol_left_q, eol_left_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic [7:0]        ascii_enc;
    logic              baud_tick;
    logic              accept;

    code_to_ascii u_code_to_ascii (
        .code_i  (code_in),
        .ascii_o (ascii_enc)
    );

    assign baud_tick = (baud_q == BAUD_LAST);
    assign accept    = code_valid && ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            ascii_q    <= 8'h00;
            eol_left_q <= 2'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            ascii_q    <= ascii_d;
            eol_left_q <= eol_left_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    // Outputs are computed for the next state so tx/busy/ready come straight from flops.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        ascii_d    = ascii_q;
        eol_left_d = eol_left_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (accept) begin
                    state_d    = ST_START;
                    shreg_d    = ascii_enc;
                    ascii_d    = ascii_enc;
                    eol_left_d = EOL_EN ? 2'd2 : 2'd0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_d    = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (eol_left_q != 2'd0) begin
                        // Line ending follows immediately with no idle gap.
                        shreg_d    = (eol_left_q == 2'd2) ? ASCII_CR : ASCII_LF;
                        ascii_d    = (eol_left_q == 2'd2) ? ASCII_CR : ASCII_LF;
                        eol_left_d = eol_left_q - 2'd1;
                        state_d    = ST_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign code_ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign ascii_out  = ascii_q;

endmodule
`default_nettype wire

// File: tb/tb_code_ascii_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_code_ascii_uart_tx                                   |
// | Brief    : Scoreboard bench for code_ascii_uart_tx (with/without EOL)|
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_code_ascii_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code0, code1, asc0, asc1;
    logic [1:0] valid_v, ready_w, tx_w, busy_w;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rst_epoch = 0;
    int         acc_cnt0 = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    code_ascii_uart_tx #(.CLKS_PER_BIT(C), .EOL_EN(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code0),
        .code_valid (valid_v[0]),
        .code_ready (ready_w[0]),
        .tx         (tx_w[0]),
        .busy       (busy_w[0]),
        .ascii_out  (asc0)
    );

    code_ascii_uart_tx #(.CLKS_PER_BIT(C), .EOL_EN(1'b1)) dut_eol (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code1),
        .code_valid (valid_v[1]),
        .code_ready (ready_w[1]),
        .tx         (tx_w[1]),
        .busy       (busy_w[1]),
        .ascii_out  (asc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Inputs are stable across the negedge, so valid&&ready here means the next edge accepts.
    always @(negedge clk) if (!reset && valid_v[0] && ready_w[0]) acc_cnt0++;

    task automatic mon(input int idx);
        logic [7:0] b;
        logic [7:0] e;
        logic       stopb;
        int         ep;
        forever begin
            @(negedge clk);
            if (!reset && tx_w[idx] == 1'b0) begin
                ep = rst_epoch;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx_w[idx];
                end
                repeat (C) @(negedge clk);
                stopb = tx_w[idx];
                if (ep == rst_epoch && !reset) begin
                    if ((idx == 0 && exp_q0.size() == 0) || (idx == 1 && exp_q1.size() == 0)) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame%0d_unexpected: got %0h expected none", idx, b);
                    end else begin
                        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("frame%0d_byte", idx), {24'd0, b}, {24'd0, e});
                        chk($sformatf("frame%0d_stop", idx), {31'd0, stopb}, 32'd1);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
        join
    end

    // Returns #1 after the accept edge (first START cycle).
    task automatic send(input int idx, input logic [7:0] code, input logic [7:0] exp,
                        input bit push, input bit hold);
        int t = 0;
        if (idx == 0) code0 = code; else code1 = code;
        valid_v[idx] = 1'b1;
        @(negedge clk);
        while (!ready_w[idx] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!ready_w[idx]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout%0d: got ready=0 expected ready=1", idx);
            valid_v[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) valid_v[idx] = 1'b0;
        if (push) begin
            if (idx == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        end
        chk($sformatf("ascii_out%0d_code%0d", idx, code),
            {24'd0, (idx == 0) ? asc0 : asc1}, {24'd0, exp});
    endtask

    task automatic wait_idle(input int idx);
        int t = 0;
        while (!(ready_w[idx] && !busy_w[idx]) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!(ready_w[idx] && !busy_w[idx])) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout%0d: got busy=%0b expected busy=0", idx, busy_w[idx]);
        end
    endtask

    initial begin
        logic [9:0] pat;
        int         base;
        int         bcnt;
        int         t;
        pat     = 10'b1001100010;
        valid_v = 2'b00;
        code0   = 8'h00;
        code1   = 8'h00;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tx%0d", i), {31'd0, tx_w[i]}, 32'd1);
            chk($sformatf("rst_busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
            chk($sformatf("rst_ready%0d", i), {31'd0, ready_w[i]}, 32'd1);
        end
        chk("rst_ascii0", {24'd0, asc0}, 32'h00);
        chk("rst_ascii1", {24'd0, asc1}, 32'h00);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Code 1: exact bit-level waveform and ready returning at cycle 41.
        send(0, 8'd1, 8'h31, 1'b1, 1'b0);
        chk("t1_ready_drop", {31'd0, ready_w[0]}, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            chk($sformatf("t1_tx_c%0d", k), {31'd0, tx_w[0]}, {31'd0, pat[(k-1)/4]});
            @(posedge clk);
            #1;
        end
        chk("t1_ready_c41", {31'd0, ready_w[0]}, 32'd1);
        chk("t1_busy_c41", {31'd0, busy_w[0]}, 32'd0);

        send(0, 8'd9,   8'h39, 1'b1, 1'b0);
        send(0, 8'd10,  8'h61, 1'b1, 1'b0);
        send(0, 8'd18,  8'h69, 1'b1, 1'b0);
        send(0, 8'd0,   8'h2A, 1'b1, 1'b0);
        send(0, 8'd19,  8'h2A, 1'b1, 1'b0);
        send(0, 8'd255, 8'h2A, 1'b1, 1'b0);
        wait_idle(0);

        // Valid held through busy: one accept per frame, single idle cycle between.
        base = acc_cnt0;
        send(0, 8'd3, 8'h33, 1'b1, 1'b1);
        code0 = 8'd4;
        repeat (40) @(posedge clk);
        #1;
        chk("t4_gap_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("t4_gap_ready", {31'd0, ready_w[0]}, 32'd1);
        @(posedge clk);
        #1;
        exp_q0.push_back(8'h34);
        valid_v[0] = 1'b0;
        chk("t4_start_tx", {31'd0, tx_w[0]}, 32'd0);
        chk("t4_ready2", {31'd0, ready_w[0]}, 32'd0);
        chk("t4_ascii2", {24'd0, asc0}, 32'h34);
        wait_idle(0);
        chk("t4_accepts", base == acc_cnt0 ? 32'd0 : acc_cnt0 - base, 32'd2);

        // EOL variant: three contiguous frames, busy exactly 120 cycles.
        send(1, 8'd5, 8'h35, 1'b1, 1'b0);
        exp_q1.push_back(8'h0D);
        exp_q1.push_back(8'h0A);
        bcnt = 0;
        for (int k = 1; k <= 130; k++) begin
            if (busy_w[1]) bcnt++;
            @(posedge clk);
            #1;
        end
        chk("t5_busy_cycles", bcnt, 32'd120);
        chk("t5_ascii_hold", {24'd0, asc1}, 32'h0A);
        chk("t5_ready", {31'd0, ready_w[1]}, 32'd1);

        // Reset during DATA bit 3 of 0x37 (bit value 0), then a clean frame.
        wait_idle(0);
        send(0, 8'd7, 8'h37, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        chk("t6_tx_bit3", {31'd0, tx_w[0]}, 32'd0);
        chk("t6_busy_pre", {31'd0, busy_w[0]}, 32'd1);
        reset = 1'b1;
        rst_epoch++;
        @(posedge clk);
        #1;
        chk("t6_rst_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("t6_rst_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("t6_rst_ready", {31'd0, ready_w[0]}, 32'd1);
        chk("t6_rst_ascii", {24'd0, asc0}, 32'h00);
        reset = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        send(0, 8'd2, 8'h32, 1'b1, 1'b0);
        wait_idle(0);

        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
